// File: rtl/argmax_classifier_if.sv
`default_nettype none
// ============================================================================
// Module   : argmax_classifier_if
// Brief    : Score-stream and result handshake bundle for argmax_classifier.
// Revision : 1.0
// ============================================================================
interface argmax_classifier_if #(
  parameter int DATA_W      = 16,
  parameter int NUM_CLASSES = 10
);
  localparam int IDX_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;

  logic                     valid_in;
  logic                     ready_out;
  logic signed [DATA_W-1:0] in_data;
  logic                     in_last;
  logic                     valid_out;
  logic                     done;
  logic [IDX_W-1:0]         class_idx;
  logic signed [DATA_W-1:0] max_score;
  logic                     reject;
  logic                     err;

  modport master (
    output valid_in, in_data, in_last,
    input  ready_out, valid_out, done, class_idx, max_score, reject, err
  );

  modport slave (
    input  valid_in, in_data, in_last,
    output ready_out, valid_out, done, class_idx, max_score, reject, err
  );
endinterface
`default_nettype wire

// File: rtl/argmax_classifier.sv
`default_nettype none
// ============================================================================
// Module   : argmax_classifier
// Brief    : Streams NUM_CLASSES signed scores per frame and emits the argmax,
//            winning score and a low-confidence reject flag.
// Revision : 1.0
// ============================================================================
module argmax_classifier #(
  parameter int                       DATA_W      = 16,
  parameter int                       NUM_CLASSES = 10,
  parameter logic signed [DATA_W-1:0] THRESHOLD   = '0
) (
  input  logic               clk,
  input  logic               rst,
  argmax_classifier_if.slave bus
);
  localparam int             IDX_W      = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  typedef enum logic [0:0] {
    S_COLLECT = 1'b0,
    S_EMIT    = 1'b1
  } state_t;

  state_t                   r_state;
  logic [IDX_W-1:0]         r_count;
  logic [IDX_W-1:0]         r_best_idx;
  logic signed [DATA_W-1:0] r_best;
  logic                     r_valid_out;
  logic                     r_done;
  logic                     r_err;
  logic [IDX_W-1:0]         r_class_idx;
  logic signed [DATA_W-1:0] r_max_score;
  logic                     r_reject;

  logic                     w_accept;
  logic                     w_take;
  logic                     w_close;
  logic signed [DATA_W-1:0] w_best;
  logic [IDX_W-1:0]         w_best_idx;

  assign w_accept   = bus.valid_in && (r_state == S_COLLECT);
  // First beat of a frame always seeds the running best; later beats need a
  // strict win so ties stay with the lower index.
  assign w_take     = (r_count == '0) || (bus.in_data > r_best);
  assign w_best     = w_take ? bus.in_data : r_best;
  assign w_best_idx = w_take ? r_count : r_best_idx;
  assign w_close    = w_accept && ((r_count == c_LAST_IDX) || bus.in_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_COLLECT;
      r_count     <= '0;
      r_best      <= '0;
      r_best_idx  <= '0;
      r_valid_out <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_class_idx <= '0;
      r_max_score <= '0;
      r_reject    <= 1'b1;
    end else begin
      r_valid_out <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      case (r_state)
        S_COLLECT: begin
          if (w_accept) begin
            r_best     <= w_best;
            r_best_idx <= w_best_idx;
            if (w_close) begin
              r_class_idx <= w_best_idx;
              r_max_score <= w_best;
              r_reject    <= (w_best <= THRESHOLD);
              r_valid_out <= 1'b1;
              r_done      <= 1'b1;
              r_err       <= bus.in_last && (r_count != c_LAST_IDX);
              r_count     <= '0;
              r_state     <= S_EMIT;
            end else begin
              r_count <= r_count + IDX_W'(1);
            end
          end
        end
        S_EMIT:  r_state <= S_COLLECT;
        default: r_state <= S_COLLECT;
      endcase
    end
  end

  assign bus.ready_out = (r_state == S_COLLECT);
  assign bus.valid_out = r_valid_out;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.class_idx = r_class_idx;
  assign bus.max_score = r_max_score;
  assign bus.reject    = r_reject;
endmodule
`default_nettype wire

// File: tb/tb_argmax_classifier.sv
`default_nettype none
// ============================================================================
// Module   : tb_argmax_classifier
// Brief    : Self-checking bench: table vectors, hand sequences and random
//            frames against an argmax reference model; also a 1-class DUT.
// Revision : 1.0
// ============================================================================
module tb_argmax_classifier;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  argmax_classifier_if #(.DATA_W(16), .NUM_CLASSES(10)) a ();
  argmax_classifier_if #(.DATA_W(16), .NUM_CLASSES(1))  b ();

  argmax_classifier #(.DATA_W(16), .NUM_CLASSES(10), .THRESHOLD(16'sd0)) u_dut_a (
    .clk(clk), .rst(rst), .bus(a)
  );
  argmax_classifier #(.DATA_W(16), .NUM_CLASSES(1), .THRESHOLD(16'sd100)) u_dut_b (
    .clk(clk), .rst(rst), .bus(b)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic signed [15:0] s [10];
    int                 len;
    bit                 last;
    int                 exp_idx;
    logic signed [15:0] exp_max;
    bit                 exp_rej;
    bit                 exp_err;
  } vec_t;

  typedef struct packed {
    logic [3:0]         idx;
    logic signed [15:0] mx;
    logic               rej;
    logic               er;
    logic               dn;
  } res_t;

  res_t resq[$];
  int   done_cnt  = 0;
  bit   prev_vo   = 1'b0;
  int   cyc       = 0;
  int   acc_cnt   = 0;
  int   stall_cnt = 0;

  always @(negedge clk) begin
    if (prev_vo) check("pulse_clear", {a.valid_out, a.done, a.err}, 0);
    if (a.valid_out) resq.push_back('{a.class_idx, a.max_score, a.reject, a.err, a.done});
    if (a.done) done_cnt++;
    prev_vo = a.valid_out;
  end

  always @(posedge clk) begin
    cyc++;
    if (!rst && a.valid_in && a.ready_out)  acc_cnt++;
    if (!rst && a.valid_in && !a.ready_out) stall_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  function automatic vec_t mkv(input logic signed [15:0] s [10], input int len, input bit last,
                               input int idx, input logic signed [15:0] mx, input bit rej, input bit er);
    vec_t v;
    v.s = s; v.len = len; v.last = last;
    v.exp_idx = idx; v.exp_max = mx; v.exp_rej = rej; v.exp_err = er;
    return v;
  endfunction

  // Reference: first index holding the largest signed score among accepted beats.
  function automatic void model(inout vec_t v);
    logic signed [15:0] best;
    int                 bi;
    best = v.s[0];
    bi   = 0;
    for (int i = 1; i < v.len; i++)
      if (v.s[i] > best) begin best = v.s[i]; bi = i; end
    v.exp_idx = bi;
    v.exp_max = best;
    v.exp_rej = (best <= 16'sd0);
    v.exp_err = (v.len < 10);
  endfunction

  task automatic drive_beat(input logic signed [15:0] d, input bit last, input int gap_pct);
    int w;
    while (int'($urandom_range(0, 99)) < gap_pct) begin
      a.valid_in = 1'b0;
      a.in_last  = 1'b0;
      @(negedge clk);
    end
    a.valid_in = 1'b1;
    a.in_data  = d;
    a.in_last  = last;
    w = 0;
    while (!a.ready_out && w < 4) begin @(negedge clk); w++; end
    if (!a.ready_out) check("ready_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_frame(input vec_t v, input int gap_pct, input string tag);
    res_t r;
    for (int i = 0; i < v.len; i++)
      drive_beat(v.s[i], (i == v.len - 1) && v.last, gap_pct);
    #1;
    check({tag, "_latency"}, resq.size(), 1);
    if (resq.size() > 0) begin
      r = resq.pop_front();
      check({tag, "_class_idx"}, r.idx, v.exp_idx);
      check({tag, "_max_score"}, $signed(r.mx), v.exp_max);
      check({tag, "_reject"}, r.rej, v.exp_rej);
      check({tag, "_err"}, r.er, v.exp_err);
      check({tag, "_done"}, r.dn, 1);
    end
    resq.delete();
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_valid_out"}, a.valid_out, 0);
    check({tag, "_done"}, a.done, 0);
    check({tag, "_err"}, a.err, 0);
    check({tag, "_class_idx"}, a.class_idx, 0);
    check({tag, "_max_score"}, $signed(a.max_score), 0);
    check({tag, "_reject"}, a.reject, 1);
    check({tag, "_ready"}, a.ready_out, 1);
  endtask

  vec_t tv [8];
  vec_t rv;
  int   c0, a0, s0, d0;
  logic signed [15:0] b_sc  [4];
  bit                 b_rej [4];

  initial begin
    tv[0] = mkv('{16'sd3, -16'sd5, 16'sd7, 16'sd2, 16'sd7, 16'sd0, 16'sd1, -16'sd1, 16'sd6, 16'sd4},
                10, 1'b0, 2, 16'sd7, 1'b0, 1'b0);
    tv[1] = mkv('{-16'sd9, -16'sd3, -16'sd4, -16'sd5, -16'sd6, -16'sd7, -16'sd32768, -16'sd10, -16'sd11, -16'sd8},
                10, 1'b0, 1, -16'sd3, 1'b1, 1'b0);
    tv[2] = mkv('{16'sd1, 16'sd2, 16'sd9, 16'sd3, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0},
                5, 1'b1, 2, 16'sd9, 1'b0, 1'b1);
    tv[3] = mkv('{16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0},
                10, 1'b0, 0, 16'sd0, 1'b1, 1'b0);
    tv[4] = mkv('{16'sd1, 16'sd1, 16'sd1, 16'sd1, 16'sd1, 16'sd1, 16'sd1, 16'sd1, 16'sd1, 16'sd5},
                10, 1'b1, 9, 16'sd5, 1'b0, 1'b0);
    tv[5] = mkv('{-16'sd32768, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0},
                1, 1'b1, 0, -16'sd32768, 1'b1, 1'b1);
    tv[6] = mkv('{16'sd0, 16'sd0, 16'sd0, 16'sd32767, 16'sd0, 16'sd0, 16'sd0, 16'sd32767, 16'sd0, 16'sd1},
                10, 1'b0, 3, 16'sd32767, 1'b0, 1'b0);
    tv[7] = mkv('{-16'sd32768, 16'sd1, -16'sd1, -16'sd32768, 16'sd0, 16'sd0, 16'sd1, -16'sd2, 16'sd0, 16'sd0},
                10, 1'b0, 1, 16'sd1, 1'b0, 1'b0);

    a.valid_in = 1'b0; a.in_data = '0; a.in_last = 1'b0;
    b.valid_in = 1'b0; b.in_data = '0; b.in_last = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_a("reset");
    check("reset_b_reject", b.reject, 1);
    check("reset_b_valid", b.valid_out, 0);

    // Table vectors, contiguous then with random gaps.
    for (int i = 0; i < 8; i++) begin
      run_frame(tv[i], 0, $sformatf("vec%0d", i));
      a.valid_in = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      run_frame(tv[i], 40, $sformatf("gapvec%0d", i));
      a.valid_in = 1'b0;
    end
    @(negedge clk);

    // valid_in held high across two frames: one EMIT stall, 20 beats in 21 edges.
    c0 = cyc; a0 = acc_cnt; s0 = stall_cnt; d0 = done_cnt;
    run_frame(tv[0], 0, "b2b_f0");
    run_frame(tv[1], 0, "b2b_f1");
    check("b2b_edges", cyc - c0, 21);
    check("b2b_accepted", acc_cnt - a0, 20);
    check("b2b_stalls", stall_cnt - s0, 1);
    check("b2b_ready_emit", a.ready_out, 0);
    a.valid_in = 1'b0;
    @(negedge clk);
    check("b2b_done_pulses", done_cnt - d0, 2);

    // Reset mid-frame discards partial frame and returns outputs to reset values.
    for (int i = 0; i < 5; i++) drive_beat(tv[6].s[i], 1'b0, 0);
    a.valid_in = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_no_result", resq.size(), 0);
    check_reset_a("midrst");
    @(negedge clk);
    run_frame(tv[0], 0, "after_rst");
    a.valid_in = 1'b0;

    // Random frames against the reference model.
    for (int f = 0; f < 30; f++) begin
      for (int i = 0; i < 10; i++) begin
        case ($urandom_range(0, 3))
          0:       rv.s[i] = -16'sd32768;
          1:       rv.s[i] = 16'($urandom);
          default: rv.s[i] = 16'(int'($urandom_range(0, 6)) - 3);
        endcase
      end
      rv.len  = int'($urandom_range(1, 10));
      rv.last = (rv.len < 10) ? 1'b1 : 1'($urandom_range(0, 1));
      model(rv);
      run_frame(rv, int'($urandom_range(0, 40)), $sformatf("rand%0d", f));
      if ($urandom_range(0, 1) == 0) a.valid_in = 1'b0;
    end
    a.valid_in = 1'b0;
    @(negedge clk);

    // Single-class instance: each beat is a frame, binary threshold decision.
    b_sc[0] = 16'sd100; b_sc[1] = 16'sd101; b_sc[2] = -16'sd1; b_sc[3] = -16'sd32768;
    b_rej[0] = 1'b1;    b_rej[1] = 1'b0;    b_rej[2] = 1'b1;   b_rej[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b.valid_in = 1'b1;
      b.in_data  = b_sc[i];
      check($sformatf("n1_ready%0d", i), b.ready_out, 1);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("n1_valid%0d", i), b.valid_out, 1);
      check($sformatf("n1_done%0d", i), b.done, 1);
      check($sformatf("n1_err%0d", i), b.err, 0);
      check($sformatf("n1_idx%0d", i), b.class_idx, 0);
      check($sformatf("n1_max%0d", i), $signed(b.max_score), b_sc[i]);
      check($sformatf("n1_reject%0d", i), b.reject, b_rej[i]);
      check($sformatf("n1_emit_ready%0d", i), b.ready_out, 0);
      b.valid_in = 1'b0;
      @(negedge clk);
      check($sformatf("n1_clear%0d", i), b.valid_out, 0);
      check($sformatf("n1_hold%0d", i), b.reject, b_rej[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/argmax_classifier.md
Name: argmax_classifier

Overview:
- Parametrised final classification stage for multi-class networks.
- Consumes a serial stream of NUM_CLASSES signed fixed-point scores, one per accepted beat, and tracks the running maximum.
- Emits a registered class index, winning score and low-confidence reject flag, with one-cycle valid_out/done pulses to the top-level FSM.
- Sits after the final dense layer and before the DONE state. With NUM_CLASSES=1 it degenerates to a binary threshold decision.

Parameters:
- DATA_W, 16, score width in bits, two's complement, format unchanged.
- NUM_CLASSES, 10, scores per frame (>=1).
- THRESHOLD, 0 (signed, DATA_W bits), reject when winning score <= THRESHOLD.
- IDX_W, max(1, clog2(NUM_CLASSES)), class index width (derived localparam).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- valid_in  in  1  score beat valid
- ready_out  out  1  block can accept a beat (combinational from state)
- in_data  in  DATA_W  signed score
- in_last  in  1  optional early end-of-frame marker
- valid_out  out  1  result valid, one-cycle pulse
- done  out  1  FSM handshake, one-cycle pulse coincident with valid_out
- class_idx  out  IDX_W  winning class index
- max_score  out  DATA_W  winning score
- reject  out  1  winning score <= THRESHOLD (binary mode: equals ~class_out semantics)
- err  out  1  frame closed by in_last before NUM_CLASSES beats, pulses with valid_out

Behaviour:
- Reset (synchronous, active-high): state=COLLECT, beat count=0, valid_out=0, done=0, err=0, class_idx=0, max_score=0, reject=1. Reset mid-frame discards the partial frame; no result is emitted.
- States:
  - COLLECT: ready_out=1.
  - EMIT: ready_out=0; lasts exactly one cycle.
- Beat accepted when valid_in && ready_out.
- Accept with count==0: best=in_data, best_idx=0.
- Accept with count>0: if in_data > best (strict signed compare), then best=in_data and best_idx=count.
  - Ties keep the lower index.
  - count increments.
- Frame closes on the accepted beat where count==NUM_CLASSES-1 OR in_last=1. On that edge:
  - The final compare includes the closing beat.
  - class_idx, max_score and reject are registered.
  - valid_out=1, done=1.
  - err=1 if closed by in_last with count<NUM_CLASSES-1.
  - count is cleared; state moves to EMIT.
- Latency: result visible the cycle after the closing beat is accepted.
- EMIT → COLLECT unconditionally next cycle. valid_out, done and err return to 0. valid_in during EMIT is not accepted, and upstream must hold the beat.
- in_last on beat NUM_CLASSES-1 is a normal close, err=0. in_last is not required.
- NUM_CLASSES=1: every accepted beat closes a frame, class_idx=0, and reject gives the binary decision.
- class_idx, max_score and reject hold their values between frames. Only valid_out, done and err are pulses.
- Gaps (valid_in=0) inside a frame are legal and do not affect the count.
- Back-to-back frames: max throughput is NUM_CLASSES beats per NUM_CLASSES+1 cycles.
- Compare is signed DATA_W. 16'h8000 is the most negative value and is a legal score.

Test Plan:
- Reset then NUM_CLASSES=10 scores [3,-5,7,2,7,0,1,-1,6,4] contiguous → one cycle after beat 9: valid_out=done=1, class_idx=2, max_score=7 (tie with idx 4 resolved low), reject=0, err=0; next cycle pulses clear.
- All scores negative [-9,-3,-4,...,-8] with THRESHOLD=0 → class_idx=1, max_score=-3, reject=1. Include 16'h8000 as one score; it must never win.
- in_last asserted with beat 4 (scores [1,2,9,3,0]) → valid_out=1, err=1, class_idx=2, max_score=9. Next frame starts at count 0 and yields err=0.
- valid_in held high across two frames → ready_out=0 in the EMIT cycle, exactly 20 beats accepted over 22 cycles, two done pulses. Insert random valid_in gaps and confirm identical results.
- Assert rst after 5 beats → no valid_out. Outputs return to reset values; the following full frame classifies correctly from count 0.
- NUM_CLASSES=1, THRESHOLD=100: scores 100, 101, -1 → three pulses with reject=1, 0, 1 and class_idx=0 each time.
